pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It watches the ID, EX and MEM stage control signals and drives the per-register write-enable and flush inputs of IF/ID, ID/EX, EX/MEM and MEM/WB, plus PC control. It handles branch redirects, load-use bubbles, data-memory wait states with a timeout, and overflow/bus-error exception entry through a request/acknowledge handshake with CP0.

---
 rtl/pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : stall/flush/redirect sequencer for the 5-stage pipe
// Revision 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  WriteReg_EX,
  input  logic        Branch_MEM,
  input  logic        Zero_MEM,
  input  logic [2:0]  BranchSt_MEM,
  input  logic        Overflow_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        dmem_ready,
  input  logic        exc_ack,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic [1:0]  pc_sel,
  output logic        epc_we,
  output logic        exc_req,
  output logic [1:0]  exc_code,
  output logic [15:0] stall_cnt,
  output logic [15:0] redirect_cnt
);

  localparam int c_CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MWAIT = 2'd1,
    S_EXC   = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_wait_cnt;
  logic [1:0]      r_exc_code;
  logic [15:0]     r_stall_cnt;
  logic [15:0]     r_redirect_cnt;

  logic            w_taken;
  logic            w_memwait;
  logic            w_loaduse;
  logic [c_CW-1:0] w_wait_next;
  logic            w_exc_entry;
  logic            w_redirect;
  logic            w_stall_inc;
  logic            w_unused;

  // Only bit 0 of the branch type distinguishes bne from beq here.
  assign w_unused    = ^BranchSt_MEM[2:1];
  assign w_taken     = Branch_MEM & (BranchSt_MEM[0] ? ~Zero_MEM : Zero_MEM);
  assign w_memwait   = (MemRead_MEM | MemWrite_MEM) & ~dmem_ready;
  assign w_loaduse   = MemRead_EX & (WriteReg_EX != 5'd0) &
                       ((WriteReg_EX == rs_ID) | (uses_rt_ID & (WriteReg_EX == rt_ID)));
  assign w_wait_next = r_wait_cnt + 1'b1;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_sel      = 2'd0;
    epc_we      = 1'b0;
    exc_req     = 1'b0;
    w_exc_entry = 1'b0;
    w_redirect  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (Overflow_MEM) begin
          w_exc_entry = 1'b1;
        end else if (w_taken) begin
          w_redirect  = 1'b1;
          pc_sel      = 2'd1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (w_memwait) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
        end else if (w_loaduse) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      S_MWAIT: begin
        if (!dmem_ready) begin
          if (w_wait_next < c_TIMEOUT) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
          end else begin
            w_exc_entry = 1'b1;
          end
        end
      end
      S_EXC: begin
        exc_req     = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_flush = 1'b1;
        if (exc_ack) begin
          pc_sel = 2'd2;
        end else begin
          pc_we  = 1'b0;
        end
      end
      default: ;
    endcase
    if (w_exc_entry) begin
      pc_we       = 1'b0;
      epc_we      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  // Exception cycles (entry and EXC) are not charged as stalls.
  assign w_stall_inc = (r_state != S_EXC) & ~pc_we & ~w_exc_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_wait_cnt     <= '0;
      r_exc_code     <= 2'd0;
      r_stall_cnt    <= 16'd0;
      r_redirect_cnt <= 16'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (Overflow_MEM) begin
            r_exc_code <= 2'd1;
            r_state    <= S_EXC;
          end else if (!w_taken && w_memwait) begin
            r_wait_cnt <= c_CW'(1);
            r_state    <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (dmem_ready) begin
            r_wait_cnt <= '0;
            r_state    <= S_RUN;
          end else if (w_wait_next < c_TIMEOUT) begin
            r_wait_cnt <= w_wait_next;
          end else begin
            r_wait_cnt <= '0;
            r_exc_code <= 2'd2;
            r_state    <= S_EXC;
          end
        end
        S_EXC: begin
          if (exc_ack) begin
            r_exc_code <= 2'd0;
            r_state    <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
      if (w_stall_inc && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_redirect && (r_redirect_cnt != 16'hFFFF))
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
    end
  end

  assign exc_code     = r_exc_code;
  assign stall_cnt    = r_stall_cnt;
  assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl : directed vector bench for pipeline_hazard_ctrl
// Revision 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_ID, rt_ID, WriteReg_EX;
  logic        uses_rt_ID, MemRead_EX, Branch_MEM, Zero_MEM;
  logic [2:0]  BranchSt_MEM;
  logic        Overflow_MEM, MemRead_MEM, MemWrite_MEM, dmem_ready, exc_ack;
  logic        pc_we, ifid_we, idex_we, exmem_we;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0]  pc_sel, exc_code;
  logic        epc_we, exc_req;
  logic [15:0] stall_cnt, redirect_cnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .MemRead_EX(MemRead_EX), .WriteReg_EX(WriteReg_EX), .Branch_MEM(Branch_MEM),
    .Zero_MEM(Zero_MEM), .BranchSt_MEM(BranchSt_MEM), .Overflow_MEM(Overflow_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .dmem_ready(dmem_ready),
    .exc_ack(exc_ack), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .pc_sel(pc_sel),
    .epc_we(epc_we), .exc_req(exc_req), .exc_code(exc_code),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  // {pc_we,ifid_we,idex_we,exmem_we, ifid_fl,idex_fl,exmem_fl,memwb_fl, pc_sel, epc_we, exc_req}
  localparam logic [11:0] c_DEF   = 12'hF00;
  localparam logic [11:0] c_LU    = 12'h340;
  localparam logic [11:0] c_BR    = 12'hFE4;
  localparam logic [11:0] c_MSTL  = 12'h010;
  localparam logic [11:0] c_ENTRY = 12'h7F2;
  localparam logic [11:0] c_EXCW  = 12'h7F1;
  localparam logic [11:0] c_ACK   = 12'hFF9;

  logic [11:0] w_outs;
  assign w_outs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
                   exmem_flush, memwb_flush, pc_sel, epc_we, exc_req};

  typedef struct {
    logic [4:0]  rs, rt, wr;
    logic        urt, mrex, br, zero;
    logic [2:0]  bst;
    logic        ovf, mrm, mwm, rdy, ack;
    logic [11:0] exp;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs[14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic urt, logic mrex,
                              logic [4:0] wr, logic br, logic zero, logic [2:0] bst,
                              logic ovf, logic mrm, logic mwm, logic rdy, logic ack,
                              logic [11:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urt = urt; v.mrex = mrex; v.wr = wr; v.br = br;
    v.zero = zero; v.bst = bst; v.ovf = ovf; v.mrm = mrm; v.mwm = mwm;
    v.rdy = rdy; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t idle(logic [11:0] exp);
    return mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endfunction

  task automatic drive(input vec_t v);
    rs_ID = v.rs; rt_ID = v.rt; uses_rt_ID = v.urt; MemRead_EX = v.mrex;
    WriteReg_EX = v.wr; Branch_MEM = v.br; Zero_MEM = v.zero; BranchSt_MEM = v.bst;
    Overflow_MEM = v.ovf; MemRead_MEM = v.mrm; MemWrite_MEM = v.mwm;
    dmem_ready = v.rdy; exc_ack = v.ack;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one vector for one clock cycle and check the combinational outputs.
  task automatic cyc(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk(name, {4'd0, w_outs}, {4'd0, v.exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(idle(c_DEF));
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_cnts(input string name, input logic [15:0] s, input logic [15:0] r,
                          input logic [1:0] code);
    chk({name, "_stall_cnt"}, stall_cnt, s);
    chk({name, "_redirect_cnt"}, redirect_cnt, r);
    chk({name, "_exc_code"}, {14'd0, exc_code}, {14'd0, code});
  endtask

  initial begin
    rst = 1'b0;
    drive(idle(c_DEF));
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", {4'd0, w_outs}, {4'd0, c_DEF});
    chk_cnts("reset", 16'd0, 16'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    //           rs     rt     urt   mrex  wr     br    zero  bst     ovf   mrm   mwm   rdy   ack   exp
    vecs[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_DEF);
    vecs[1]  = mk(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_LU);
    vecs[2]  = mk(5'd0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_DEF);
    vecs[3]  = mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_LU);
    vecs[4]  = mk(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_DEF);
    vecs[5]  = mk(5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_DEF);
    vecs[6]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_BR);
    vecs[7]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_DEF);
    vecs[8]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_BR);
    vecs[9]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_DEF);
    vecs[10] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_BR);
    vecs[11] = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_BR);
    vecs[12] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_DEF);
    vecs[13] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, c_DEF);

    for (int i = 0; i < 14; i++)
      cyc($sformatf("vec%0d", i), vecs[i]);
    cyc("table_after", idle(c_DEF));
    chk_cnts("table", 16'd2, 16'd4, 2'd0);

    // Load-use: one bubble; r0 destination never stalls.
    do_reset();
    cyc("lu_stall", vecs[1]);
    cyc("lu_release", idle(c_DEF));
    chk_cnts("lu", 16'd1, 16'd0, 2'd0);
    cyc("lu_r0", vecs[2]);
    cyc("lu_r0_after", idle(c_DEF));
    chk("lu_r0_stall_cnt", stall_cnt, 16'd1);

    // Taken bne, alone then with load-use.
    do_reset();
    cyc("br_bne", vecs[6]);
    cyc("br_after", idle(c_DEF));
    chk_cnts("br", 16'd0, 16'd1, 2'd0);
    cyc("br_with_lu", vecs[11]);
    cyc("br_lu_after", idle(c_DEF));
    chk_cnts("br_lu", 16'd0, 16'd2, 2'd0);

    // Memory wait of 3 cycles, then advance.
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc($sformatf("mw_stall%0d", i),
          mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c_MSTL));
    cyc("mw_ready", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, c_DEF));
    cyc("mw_back_run", idle(c_DEF));
    chk_cnts("mw", 16'd3, 16'd0, 2'd0);

    // Bus-error timeout: 15 stalls, entry, 4 EXC cycles, ack.
    do_reset();
    for (int i = 0; i < 15; i++)
      cyc($sformatf("to_stall%0d", i),
          mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c_MSTL));
    cyc("to_entry", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c_ENTRY));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("to_exc%0d", i), idle(c_EXCW));
    chk_cnts("to_exc", 16'd15, 16'd0, 2'd2);
    cyc("to_ack", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_ACK));
    cyc("to_run", idle(c_DEF));
    chk_cnts("to_run", 16'd15, 16'd0, 2'd0);
    cyc("ack_in_run", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_DEF));

    // Overflow with a taken branch: exception wins; EXC ignores the branch.
    do_reset();
    cyc("ovf_entry", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_ENTRY));
    cyc("ovf_exc", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_EXCW));
    chk_cnts("ovf", 16'd0, 16'd0, 2'd1);
    cyc("ovf_ack", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_ACK));
    cyc("ovf_run", idle(c_DEF));
    chk_cnts("ovf_run", 16'd0, 16'd0, 2'd0);

    // Asynchronous reset while in MWAIT.
    do_reset();
    cyc("rm_enter", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c_MSTL));
    cyc("rm_in_mwait", idle(c_MSTL));
    #2 rst = 1'b1;
    #1;
    chk("rm_reset_outs", {4'd0, w_outs}, {4'd0, c_DEF});
    chk_cnts("rm_reset", 16'd0, 16'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("rm_resume", vecs[1]);

    // Asynchronous reset while in EXC.
    do_reset();
    cyc("re_entry", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_ENTRY));
    cyc("re_in_exc", idle(c_EXCW));
    #2 rst = 1'b1;
    #1;
    chk("re_reset_outs", {4'd0, w_outs}, {4'd0, c_DEF});
    chk_cnts("re_reset", 16'd0, 16'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("re_resume", vecs[6]);
    cyc("re_after", idle(c_DEF));
    chk("re_redirect_cnt", redirect_cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
